mem_arbiter_2x1: RTL and testbench

// - Shares one memory port between two requesters: port 0 = instruction fetch, port 1 = data (load/store).
// - Round-robin arbitration with grant lock while the memory side back-pressures.
// - Tags each request with a requester-ID bit in the opaque MSB; routes responses back by that bit.
// - Sits between the core's fetch/data units and the single memory/cache client port.

---
 rtl/mem_arbiter_2x1_pkg.sv | 34 +++
 rtl/mem_arbiter_2x1_checker.sv | 34 +++
 rtl/mem_arbiter_2x1_inflight_counter.sv | 61 ++++++
 rtl/mem_arbiter_2x1.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter_2x1.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_2x1_pkg.sv
// Shared memory-message definitions for the 2:1 memory arbiter: opcodes,
// default field layout and width helpers used to size the message buses.
package mem_arbiter_2x1_pkg;

  typedef enum logic [0:0] {
    MEM_MSG_READ  = 1'b0,
    MEM_MSG_WRITE = 1'b1
  } mem_msg_type_e;

  localparam int unsigned MEM_ADDR_BITS_DFLT = 32;
  localparam int unsigned MEM_DATA_BITS_DFLT = 32;
  localparam int unsigned MEM_OPAQ_BITS_DFLT = 8;

  // Byte-length field wide enough to express a full data word.
  function automatic int unsigned mem_len_bits(input int unsigned data_bits);
    return $clog2(data_bits / 8);
  endfunction

  // Request/response layout is {op, opaque, addr, len, data}, op in the MSB.
  function automatic int unsigned mem_msg_bits(input int unsigned opaq_bits,
                                               input int unsigned addr_bits,
                                               input int unsigned data_bits);
    return 1 + opaq_bits + addr_bits + mem_len_bits(data_bits) + data_bits;
  endfunction

  typedef struct packed {
    mem_msg_type_e op;
    logic [MEM_OPAQ_BITS_DFLT-1:0] opaque;
    logic [MEM_ADDR_BITS_DFLT-1:0] addr;
    logic [1:0]                    len;
    logic [MEM_DATA_BITS_DFLT-1:0] data;
  } mem_req_msg_t;

endpackage

// File: rtl/mem_arbiter_2x1_checker.sv
// Simulation-only protocol checker: a requester whose request stalled must
// keep its valid asserted on the following cycle until the memory accepts it.
module mem_arbiter_2x1_checker (
  input logic clk,
  input logic rst,
  input logic req0_val,
  input logic req1_val,
  input logic mem_req_val,
  input logic mem_req_rdy,
  input logic mem_req_id
);

  logic stall_r;
  logic stall_id_r;

  // remember whether the previous cycle ended in a stall and for whom
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_r    <= 1'b0;
      stall_id_r <= 1'b0;
    end else begin
      stall_r    <= mem_req_val & ~mem_req_rdy;
      stall_id_r <= mem_req_id;
    end
  end

  // the locked requester may not withdraw its request
  always @(posedge clk) begin
    if (!rst && stall_r) begin
      assert (stall_id_r ? req1_val : req0_val);
    end
  end

endmodule

// File: rtl/mem_arbiter_2x1_inflight_counter.sv
// Per-requester outstanding-request counter: increments on request transfer,
// decrements on response transfer, saturates at zero, flags full at the limit.
module arb_inflight_counter #(
  parameter int unsigned p_max_in_flight = 4,
  localparam int unsigned p_cnt_bits = $clog2(p_max_in_flight) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic full
);

  logic [p_cnt_bits-1:0] cnt_r;
  logic [p_cnt_bits-1:0] cnt_nxt_s;
  logic                  full_s;

  // full when the outstanding count reaches the configured limit
  always_comb begin
    full_s = 1'b0;
    if (cnt_r == p_cnt_bits'(p_max_in_flight)) begin
      full_s = 1'b1;
    end else begin
      full_s = 1'b0;
    end
  end

  // next count; simultaneous inc and dec cancel, stale decrements stop at zero
  always_comb begin
    cnt_nxt_s = cnt_r;
    case ({inc, dec})
      2'b10: begin
        if (!full_s) begin
          cnt_nxt_s = cnt_r + p_cnt_bits'(1);
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      2'b01: begin
        if (cnt_r != {p_cnt_bits{1'b0}}) begin
          cnt_nxt_s = cnt_r - p_cnt_bits'(1);
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {p_cnt_bits{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign full = full_s;

endmodule

// File: rtl/mem_arbiter_2x1.sv
// Two-requester memory arbiter: round-robin grant with lock under back-pressure,
// requester-ID tagging in the opaque MSB, and ID-based response routing.
module mem_arbiter_2x1
  import mem_arbiter_2x1_pkg::*;
#(
  parameter int unsigned p_addr_bits     = MEM_ADDR_BITS_DFLT,
  parameter int unsigned p_data_bits     = MEM_DATA_BITS_DFLT,
  parameter int unsigned p_opaq_bits     = MEM_OPAQ_BITS_DFLT,
  parameter int unsigned p_max_in_flight = 4,
  localparam int unsigned p_req_w  = mem_msg_bits(p_opaq_bits, p_addr_bits, p_data_bits),
  localparam int unsigned p_mreq_w = p_req_w + 1
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                req0_val,
  output logic                req0_rdy,
  input  logic [p_req_w-1:0]  req0_msg,
  input  logic                req1_val,
  output logic                req1_rdy,
  input  logic [p_req_w-1:0]  req1_msg,

  output logic                resp0_val,
  input  logic                resp0_rdy,
  output logic [p_req_w-1:0]  resp0_msg,
  output logic                resp1_val,
  input  logic                resp1_rdy,
  output logic [p_req_w-1:0]  resp1_msg,

  output logic                mem_req_val,
  input  logic                mem_req_rdy,
  output logic [p_mreq_w-1:0] mem_req_msg,
  input  logic                mem_resp_val,
  output logic                mem_resp_rdy,
  input  logic [p_mreq_w-1:0] mem_resp_msg
);

  // The ID bit sits directly below the op bit in the widened memory message.
  localparam int unsigned p_id_pos = p_req_w - 1;

  logic                prio_r;
  logic                lock_val_r;
  logic                lock_id_r;

  logic                full0_s;
  logic                full1_s;
  logic                elig0_s;
  logic                elig1_s;
  logic                grant_s;
  logic [p_req_w-1:0]  sel_msg_s;
  logic                req_xfer_s;
  logic                resp_id_s;
  logic                resp_xfer_s;
  logic [p_req_w-1:0]  resp_msg_s;

  // eligibility and grant selection; a held lock overrides round-robin
  always_comb begin
    elig0_s = req0_val & ~full0_s;
    elig1_s = req1_val & ~full1_s;
    grant_s = 1'b0;
    if (lock_val_r) begin
      grant_s = lock_id_r;
    end else if (elig0_s && elig1_s) begin
      grant_s = prio_r;
    end else begin
      grant_s = elig1_s;
    end
  end

  // request path: forward the granted message with its ID spliced into opaque
  always_comb begin
    sel_msg_s   = {p_req_w{1'b0}};
    mem_req_val = 1'b0;
    req0_rdy    = 1'b0;
    req1_rdy    = 1'b0;
    if (grant_s) begin
      sel_msg_s   = req1_msg;
      mem_req_val = elig1_s;
      req1_rdy    = mem_req_rdy & elig1_s;
    end else begin
      sel_msg_s   = req0_msg;
      mem_req_val = elig0_s;
      req0_rdy    = mem_req_rdy & elig0_s;
    end
    mem_req_msg = {sel_msg_s[p_req_w-1], grant_s, sel_msg_s[p_req_w-2:0]};
    req_xfer_s  = mem_req_val & mem_req_rdy;
  end

  // response path: route by the returned ID bit and strip it from opaque
  always_comb begin
    resp_id_s    = mem_resp_msg[p_id_pos];
    resp_msg_s   = {mem_resp_msg[p_mreq_w-1], mem_resp_msg[p_id_pos-1:0]};
    resp0_val    = 1'b0;
    resp1_val    = 1'b0;
    mem_resp_rdy = 1'b0;
    if (resp_id_s) begin
      resp1_val    = mem_resp_val;
      mem_resp_rdy = resp1_rdy;
    end else begin
      resp0_val    = mem_resp_val;
      mem_resp_rdy = resp0_rdy;
    end
    resp0_msg   = resp_msg_s;
    resp1_msg   = resp_msg_s;
    resp_xfer_s = mem_resp_val & mem_resp_rdy;
  end

  // round-robin pointer and stall lock; a transfer releases the lock
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_r     <= 1'b0;
      lock_val_r <= 1'b0;
      lock_id_r  <= 1'b0;
    end else if (req_xfer_s) begin
      prio_r     <= ~grant_s;
      lock_val_r <= 1'b0;
      lock_id_r  <= lock_id_r;
    end else if (mem_req_val) begin
      prio_r     <= prio_r;
      lock_val_r <= 1'b1;
      lock_id_r  <= grant_s;
    end else begin
      prio_r     <= prio_r;
      lock_val_r <= lock_val_r;
      lock_id_r  <= lock_id_r;
    end
  end

  arb_inflight_counter #(
    .p_max_in_flight (p_max_in_flight)
  ) u_cnt0 (
    .clk  (clk),
    .rst  (rst),
    .inc  (req_xfer_s & ~grant_s),
    .dec  (resp_xfer_s & ~resp_id_s),
    .full (full0_s)
  );

  arb_inflight_counter #(
    .p_max_in_flight (p_max_in_flight)
  ) u_cnt1 (
    .clk  (clk),
    .rst  (rst),
    .inc  (req_xfer_s & grant_s),
    .dec  (resp_xfer_s & resp_id_s),
    .full (full1_s)
  );

endmodule

// File: tb/tb_mem_arbiter_2x1.sv
// Self-checking bench for mem_arbiter_2x1: per-scenario tasks plus a
// scoreboard that matches every memory-side and response-side transfer.
module tb_mem_arbiter_2x1;
  import mem_arbiter_2x1_pkg::*;

  localparam int RW = 75;
  localparam int MW = 76;

  typedef struct {
    logic          id;
    logic [RW-1:0] msg;
  } resp_exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_val, req0_rdy, req1_val, req1_rdy;
  logic [RW-1:0] req0_msg, req1_msg;
  logic          resp0_val, resp0_rdy, resp1_val, resp1_rdy;
  logic [RW-1:0] resp0_msg, resp1_msg;
  logic          mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;
  logic [MW-1:0] mem_req_msg, mem_resp_msg;

  int total = 0;
  int bad   = 0;

  logic [MW-1:0] req_q[$];
  resp_exp_t     resp_q[$];
  logic [MW-1:0] mon_req_exp;
  resp_exp_t     mon_resp_exp;
  logic [RW-1:0] mon_resp_got;

  always #5 clk = ~clk;

  mem_arbiter_2x1 dut (
    .clk(clk), .rst(rst),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_msg(mem_req_msg),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_msg(mem_resp_msg)
  );

  mem_arbiter_2x1_checker u_chk (
    .clk(clk), .rst(rst), .req0_val(req0_val), .req1_val(req1_val),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_id(mem_req_msg[MW-2])
  );

  function automatic logic [RW-1:0] mk(input logic op, input logic [7:0] opq,
                                       input logic [31:0] addr, input logic [1:0] len,
                                       input logic [31:0] data);
    return {op, opq, addr, len, data};
  endfunction

  function automatic logic [MW-1:0] mkm(input logic op, input logic [8:0] opq,
                                        input logic [31:0] addr, input logic [1:0] len,
                                        input logic [31:0] data);
    return {op, opq, addr, len, data};
  endfunction

  // Scoreboard: every transfer on either memory-side channel must match the next expectation.
  always @(negedge clk) begin
    #2;
    if (!rst && mem_req_val && mem_req_rdy) begin
      total++;
      if (req_q.size() == 0) begin
        bad++;
        $display("FAIL sb_req unexpected got=%h exp=none", mem_req_msg);
      end else begin
        mon_req_exp = req_q.pop_front();
        if (mem_req_msg !== mon_req_exp) begin
          bad++;
          $display("FAIL sb_req got=%h exp=%h", mem_req_msg, mon_req_exp);
        end
      end
    end
    if (!rst && mem_resp_val && mem_resp_rdy) begin
      total++;
      if (resp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_resp unexpected vals=%b%b", resp1_val, resp0_val);
      end else begin
        mon_resp_exp = resp_q.pop_front();
        mon_resp_got = mon_resp_exp.id ? resp1_msg : resp0_msg;
        if ({resp1_val, resp0_val, mon_resp_got} !==
            {mon_resp_exp.id, ~mon_resp_exp.id, mon_resp_exp.msg}) begin
          bad++;
          $display("FAIL sb_resp got=%b%b/%h exp_id=%b/%h", resp1_val, resp0_val,
                   mon_resp_got, mon_resp_exp.id, mon_resp_exp.msg);
        end
      end
    end
  end

  task automatic idle();
    req0_val = 1'b0; req1_val = 1'b0;
    req0_msg = '0;   req1_msg = '0;
    mem_req_rdy = 1'b0; mem_resp_val = 1'b0; mem_resp_msg = '0;
    resp0_rdy = 1'b0; resp1_rdy = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({mem_req_val, req0_rdy, req1_rdy, resp0_val, resp1_val, mem_resp_rdy} !== 6'b000000) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=000000",
               {mem_req_val, req0_rdy, req1_rdy, resp0_val, resp1_val, mem_resp_rdy});
    end
    @(negedge clk);
    rst = 1'b0;
    req0_val = 1'b1; req0_msg = mk(MEM_MSG_READ, 8'h11, 32'h0, 2'd3, 32'h0);
    req1_val = 1'b1; req1_msg = mk(MEM_MSG_READ, 8'h22, 32'h4, 2'd3, 32'h0);
    #1;
    total++;
    if ({mem_req_val, mem_req_msg[MW-2]} !== 2'b10) begin
      bad++;
      $display("FAIL reset_first_prio got=%b exp=10", {mem_req_val, mem_req_msg[MW-2]});
    end
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    req0_val = 1'b1;
    req0_msg = mk(MEM_MSG_READ, 8'h05, 32'h100, 2'd3, 32'h0);
    mem_req_rdy = 1'b1;
    req_q.push_back(mkm(MEM_MSG_READ, 9'h005, 32'h100, 2'd3, 32'h0));
    #1;
    total++;
    if ({mem_req_val, req0_rdy, req1_rdy} !== 3'b110) begin
      bad++;
      $display("FAIL single_handshake got=%b exp=110", {mem_req_val, req0_rdy, req1_rdy});
    end
    total++;
    if (mem_req_msg[MW-2 -: 9] !== 9'h005) begin
      bad++;
      $display("FAIL single_opaque got=%h exp=005", mem_req_msg[MW-2 -: 9]);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_alternate();
    logic [31:0] d0, d1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      d0 = $urandom;
      d1 = $urandom;
      req0_val = 1'b1; req0_msg = mk(MEM_MSG_WRITE, 8'(i), 32'h1000 + 32'(i * 4), 2'd3, d0);
      req1_val = 1'b1; req1_msg = mk(MEM_MSG_READ, 8'h80 | 8'(i), 32'h2000 + 32'(i * 4), 2'd2, d1);
      mem_req_rdy = 1'b1;
      if (i % 2 == 0) req_q.push_back(mkm(MEM_MSG_WRITE, {1'b0, 8'(i)}, 32'h1000 + 32'(i * 4), 2'd3, d0));
      else            req_q.push_back(mkm(MEM_MSG_READ, {1'b1, 8'h80 | 8'(i)}, 32'h2000 + 32'(i * 4), 2'd2, d1));
      #1;
      total++;
      if ({req1_rdy, req0_rdy} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        bad++;
        $display("FAIL alternate_grant cycle=%0d got=%b exp=%b", i, {req1_rdy, req0_rdy},
                 ((i % 2 == 0) ? 2'b01 : 2'b10));
      end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_lock();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req1_val = 1'b1; req1_msg = mk(MEM_MSG_WRITE, 8'h31, 32'h3000, 2'd3, 32'hCAFE_F00D);
      req0_val = (c != 0); req0_msg = mk(MEM_MSG_READ, 8'h30, 32'h300, 2'd3, 32'h0);
      mem_req_rdy = 1'b0;
      #1;
      total++;
      if ({mem_req_val, mem_req_msg[MW-2], req0_rdy, req1_rdy} !== 4'b1100) begin
        bad++;
        $display("FAIL lock_hold cycle=%0d got=%b exp=1100", c,
                 {mem_req_val, mem_req_msg[MW-2], req0_rdy, req1_rdy});
      end
    end
    @(negedge clk);
    mem_req_rdy = 1'b1;
    req_q.push_back(mkm(MEM_MSG_WRITE, 9'h131, 32'h3000, 2'd3, 32'hCAFE_F00D));
    #1;
    total++;
    if ({req1_rdy, req0_rdy} !== 2'b10) begin
      bad++;
      $display("FAIL lock_release got=%b exp=10", {req1_rdy, req0_rdy});
    end
    @(negedge clk);
    req1_msg = mk(MEM_MSG_WRITE, 8'h32, 32'h3004, 2'd3, 32'h0BAD_BEEF);
    req_q.push_back(mkm(MEM_MSG_READ, 9'h030, 32'h300, 2'd3, 32'h0));
    #1;
    total++;
    if ({req1_rdy, req0_rdy} !== 2'b01) begin
      bad++;
      $display("FAIL lock_then_port0 got=%b exp=01", {req1_rdy, req0_rdy});
    end
    @(negedge clk);
    req0_val = 1'b0;
    req_q.push_back(mkm(MEM_MSG_WRITE, 9'h132, 32'h3004, 2'd3, 32'h0BAD_BEEF));
    @(negedge clk);
    idle();
  endtask

  task automatic test_resp_route();
    do_reset();
    @(negedge clk);
    mem_resp_val = 1'b1;
    mem_resp_msg = mkm(MEM_MSG_READ, 9'h1A7, 32'hDEAD_0000, 2'd3, 32'h1234_5678);
    resp0_rdy = 1'b1; resp1_rdy = 1'b0;
    #1;
    total++;
    if ({resp1_val, resp0_val, mem_resp_rdy} !== 3'b100) begin
      bad++;
      $display("FAIL resp_route_stall got=%b exp=100", {resp1_val, resp0_val, mem_resp_rdy});
    end
    total++;
    if (resp1_msg !== mk(MEM_MSG_READ, 8'hA7, 32'hDEAD_0000, 2'd3, 32'h1234_5678)) begin
      bad++;
      $display("FAIL resp_strip got=%h exp_opaque=a7", resp1_msg);
    end
    @(negedge clk);
    resp1_rdy = 1'b1;
    resp_q.push_back('{1'b1, mk(MEM_MSG_READ, 8'hA7, 32'hDEAD_0000, 2'd3, 32'h1234_5678)});
    #1;
    total++;
    if (mem_resp_rdy !== 1'b1) begin
      bad++;
      $display("FAIL resp_rdy1 got=%b exp=1", mem_resp_rdy);
    end
    @(negedge clk);
    mem_resp_msg = mkm(MEM_MSG_WRITE, 9'h033, 32'h44, 2'd1, 32'h9);
    resp1_rdy = 1'b0;
    resp_q.push_back('{1'b0, mk(MEM_MSG_WRITE, 8'h33, 32'h44, 2'd1, 32'h9)});
    #1;
    total++;
    if ({resp1_val, resp0_val, mem_resp_rdy} !== 3'b011) begin
      bad++;
      $display("FAIL resp_route0 got=%b exp=011", {resp1_val, resp0_val, mem_resp_rdy});
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_max_in_flight();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req0_val = 1'b1; req0_msg = mk(MEM_MSG_READ, 8'h40 + 8'(i), 32'h400 + 32'(i), 2'd0, 32'h0);
      mem_req_rdy = 1'b1;
      req_q.push_back(mkm(MEM_MSG_READ, 9'h040 + 9'(i), 32'h400 + 32'(i), 2'd0, 32'h0));
      #1;
      total++;
      if (req0_rdy !== 1'b1) begin
        bad++;
        $display("FAIL max_fill cycle=%0d got=%b exp=1", i, req0_rdy);
      end
    end
    @(negedge clk);
    req0_msg = mk(MEM_MSG_READ, 8'h50, 32'h500, 2'd0, 32'h0);
    req1_val = 1'b1; req1_msg = mk(MEM_MSG_WRITE, 8'h51, 32'h510, 2'd3, 32'h77);
    req_q.push_back(mkm(MEM_MSG_WRITE, 9'h151, 32'h510, 2'd3, 32'h77));
    #1;
    total++;
    if ({req1_rdy, req0_rdy} !== 2'b10) begin
      bad++;
      $display("FAIL max_other_proceeds got=%b exp=10", {req1_rdy, req0_rdy});
    end
    @(negedge clk);
    req1_val = 1'b0;
    mem_resp_val = 1'b1; mem_resp_msg = mkm(MEM_MSG_READ, 9'h040, 32'h400, 2'd0, 32'h1);
    resp0_rdy = 1'b1;
    resp_q.push_back('{1'b0, mk(MEM_MSG_READ, 8'h40, 32'h400, 2'd0, 32'h1)});
    #1;
    total++;
    if ({mem_req_val, req0_rdy} !== 2'b00) begin
      bad++;
      $display("FAIL max_masked got=%b exp=00", {mem_req_val, req0_rdy});
    end
    @(negedge clk);
    mem_resp_msg = mkm(MEM_MSG_READ, 9'h041, 32'h401, 2'd0, 32'h2);
    resp_q.push_back('{1'b0, mk(MEM_MSG_READ, 8'h41, 32'h401, 2'd0, 32'h2)});
    req_q.push_back(mkm(MEM_MSG_READ, 9'h050, 32'h500, 2'd0, 32'h0));
    #1;
    total++;
    if (req0_rdy !== 1'b1) begin
      bad++;
      $display("FAIL max_reenabled got=%b exp=1", req0_rdy);
    end
    @(negedge clk);
    mem_resp_val = 1'b0;
    req0_msg = mk(MEM_MSG_READ, 8'h52, 32'h520, 2'd0, 32'h0);
    req_q.push_back(mkm(MEM_MSG_READ, 9'h052, 32'h520, 2'd0, 32'h0));
    #1;
    total++;
    if (req0_rdy !== 1'b1) begin
      bad++;
      $display("FAIL max_inc_dec_cancel got=%b exp=1", req0_rdy);
    end
    @(negedge clk);
    req0_msg = mk(MEM_MSG_READ, 8'h53, 32'h530, 2'd0, 32'h0);
    #1;
    total++;
    if (req0_rdy !== 1'b0) begin
      bad++;
      $display("FAIL max_full_again got=%b exp=0", req0_rdy);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    @(negedge clk);
    req0_val = 1'b1; req0_msg = mk(MEM_MSG_WRITE, 8'h60, 32'h600, 2'd3, 32'h6);
    mem_req_rdy = 1'b0;
    #1;
    total++;
    if ({mem_req_val, req0_rdy} !== 2'b10) begin
      bad++;
      $display("FAIL mid_stall got=%b exp=10", {mem_req_val, req0_rdy});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req0_val = 1'b0;
    req1_val = 1'b1; req1_msg = mk(MEM_MSG_READ, 8'h61, 32'h610, 2'd3, 32'h0);
    mem_req_rdy = 1'b1;
    req_q.push_back(mkm(MEM_MSG_READ, 9'h161, 32'h610, 2'd3, 32'h0));
    #1;
    total++;
    if ({req1_rdy, req0_rdy} !== 2'b10) begin
      bad++;
      $display("FAIL mid_lock_cleared got=%b exp=10", {req1_rdy, req0_rdy});
    end
    @(negedge clk);
    req1_val = 1'b0; mem_req_rdy = 1'b0;
    mem_resp_val = 1'b1; mem_resp_msg = mkm(MEM_MSG_READ, 9'h062, 32'h620, 2'd3, 32'hABCD);
    resp0_rdy = 1'b1;
    resp_q.push_back('{1'b0, mk(MEM_MSG_READ, 8'h62, 32'h620, 2'd3, 32'hABCD)});
    #1;
    total++;
    if ({resp0_val, resp1_val, mem_resp_rdy} !== 3'b101) begin
      bad++;
      $display("FAIL mid_stray_route got=%b exp=101", {resp0_val, resp1_val, mem_resp_rdy});
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mem_resp_val = 1'b0;
      req0_val = 1'b1; req0_msg = mk(MEM_MSG_READ, 8'h70 + 8'(i), 32'h700, 2'd3, 32'h0);
      mem_req_rdy = 1'b1;
      if (i < 4) req_q.push_back(mkm(MEM_MSG_READ, 9'h070 + 9'(i), 32'h700, 2'd3, 32'h0));
      #1;
      total++;
      if (req0_rdy !== (i < 4)) begin
        bad++;
        $display("FAIL mid_cnt_no_underflow cycle=%0d got=%b exp=%b", i, req0_rdy, (i < 4));
      end
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_single();
    test_alternate();
    test_lock();
    test_resp_route();
    test_max_in_flight();
    test_reset_mid_stall();
    @(negedge clk);
    #3;
    total++;
    if (req_q.size() != 0 || resp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got=%0d/%0d exp=0/0", req_q.size(), resp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
